// File: rtl/memctrl.sv
// memctrl: dcache/icache responder serializing requests onto a byte-wide RAM/IO bus.
// Dcache requests win arbitration; each request ends with a one-cycle done pulse.
module memctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        iDC_en,
  input  logic        iDC_ls,
  input  logic [31:0] iDC_pc,
  input  logic [31:0] iDC_dt,
  input  logic [2:0]  iDC_len,
  output logic        oDC_done,
  output logic [31:0] oDC_dt,
  input  logic        iIC_en,
  input  logic [31:0] iIC_pc,
  output logic        oIC_done,
  output logic [31:0] oIC_dt,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_IOWAIT
  } state_t;

  state_t state_q, state_d;

  logic [2:0]  cnt_q, cnt_d;
  logic        cur_ic_q, cur_ic_d;
  logic [31:0] cur_pc_q, cur_pc_d;
  logic [2:0]  cur_n_q, cur_n_d;
  logic [31:0] buf_q, buf_d;

  logic        pend_v_q, pend_v_d;
  logic        pend_ls_q, pend_ls_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] pend_dt_q, pend_dt_d;
  logic [2:0]  pend_n_q, pend_n_d;

  logic        dc_done_q, dc_done_d;
  logic [31:0] dc_dt_q, dc_dt_d;
  logic        ic_done_q, ic_done_d;
  logic [31:0] ic_dt_q, ic_dt_d;

  logic        req_ls;
  logic [31:0] req_pc;
  logic [2:0]  req_n;
  logic [2:0]  in_n;
  logic [2:0]  a_idx;
  logic [31:0] byte_a;
  logic        stall;
  logic [31:0] rd_buf;
  logic [31:0] dt_sh;

  assign oDC_done = dc_done_q;
  assign oDC_dt   = dc_dt_q;
  assign oIC_done = ic_done_q;
  assign oIC_dt   = ic_dt_q;

  // Byte index on the bus; a frozen read re-issues the byte still owed
  // so that mem_din is correct again when rdy returns.
  always_comb begin
    in_n = (iDC_len == 3'd1) ? 3'd1 :
           (iDC_len == 3'd2) ? 3'd2 : 3'd4;
    a_idx = cnt_q;
    if (state_q == S_READ && !rdy && cnt_q != 3'd0)
      a_idx = cnt_q - 3'd1;
    byte_a = cur_pc_q + {29'b0, a_idx};
    stall  = (byte_a[17:16] == 2'b11) && io_buffer_full;
    dt_sh  = pend_dt_q >> {cnt_q[1:0], 3'b000};
    rd_buf = buf_q;
    for (int i = 0; i < 4; i++)
      if (cnt_q == 3'(i + 1))
        rd_buf[8*i +: 8] = mem_din;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else if (rdy)
      state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      cur_ic_q  <= 1'b0;
      cur_pc_q  <= '0;
      cur_n_q   <= '0;
      buf_q     <= '0;
      pend_v_q  <= 1'b0;
      pend_ls_q <= 1'b0;
      pend_pc_q <= '0;
      pend_dt_q <= '0;
      pend_n_q  <= '0;
      dc_done_q <= 1'b0;
      dc_dt_q   <= '0;
      ic_done_q <= 1'b0;
      ic_dt_q   <= '0;
    end else if (rdy) begin
      cnt_q     <= cnt_d;
      cur_ic_q  <= cur_ic_d;
      cur_pc_q  <= cur_pc_d;
      cur_n_q   <= cur_n_d;
      buf_q     <= buf_d;
      pend_v_q  <= pend_v_d;
      pend_ls_q <= pend_ls_d;
      pend_pc_q <= pend_pc_d;
      pend_dt_q <= pend_dt_d;
      pend_n_q  <= pend_n_d;
      dc_done_q <= dc_done_d;
      dc_dt_q   <= dc_dt_d;
      ic_done_q <= ic_done_d;
      ic_dt_q   <= ic_dt_d;
    end
  end

  // Next state: capture, arbitration, byte sequencing, completion
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_ic_d  = cur_ic_q;
    cur_pc_d  = cur_pc_q;
    cur_n_d   = cur_n_q;
    buf_d     = buf_q;
    pend_v_d  = pend_v_q;
    pend_ls_d = pend_ls_q;
    pend_pc_d = pend_pc_q;
    pend_dt_d = pend_dt_q;
    pend_n_d  = pend_n_q;
    dc_done_d = 1'b0;
    dc_dt_d   = dc_dt_q;
    ic_done_d = 1'b0;
    ic_dt_d   = ic_dt_q;

    req_ls = pend_v_q ? pend_ls_q : iDC_ls;
    req_pc = pend_v_q ? pend_pc_q : iDC_pc;
    req_n  = pend_v_q ? pend_n_q  : in_n;

    if (iDC_en && !pend_v_q) begin
      pend_v_d  = 1'b1;
      pend_ls_d = iDC_ls;
      pend_pc_d = iDC_pc;
      pend_dt_d = iDC_dt;
      pend_n_d  = in_n;
    end

    unique case (state_q)
      S_IDLE: begin
        if (pend_v_q || iDC_en) begin
          cur_ic_d = 1'b0;
          cur_pc_d = req_pc;
          cur_n_d  = req_n;
          cnt_d    = '0;
          buf_d    = '0;
          state_d  = req_ls ? S_WRITE : S_READ;
        end else if (iIC_en && !ic_done_q) begin
          cur_ic_d = 1'b1;
          cur_pc_d = iIC_pc;
          cur_n_d  = 3'd4;
          cnt_d    = '0;
          buf_d    = '0;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        buf_d = rd_buf;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == cur_n_q) begin
          state_d = S_IDLE;
          if (cur_ic_q) begin
            ic_done_d = 1'b1;
            ic_dt_d   = rd_buf;
          end else begin
            dc_done_d = 1'b1;
            dc_dt_d   = rd_buf;
            pend_v_d  = 1'b0;
          end
        end
      end
      S_WRITE, S_IOWAIT: begin
        if (stall) begin
          state_d = S_IOWAIT;
        end else begin
          cnt_d = cnt_q + 3'd1;
          state_d = S_WRITE;
          if (cnt_q == cur_n_q - 3'd1) begin
            state_d   = S_IDLE;
            dc_done_d = 1'b1;
            dc_dt_d   = '0;
            pend_v_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    unique case (state_q)
      S_READ: begin
        if (a_idx < cur_n_q)
          mem_a = byte_a;
      end
      S_WRITE, S_IOWAIT: begin
        mem_a = byte_a;
        if (!stall && rdy) begin
          mem_wr   = 1'b1;
          mem_dout = dt_sh[7:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memctrl.sv
// tb_memctrl: directed checks of memctrl against a byte RAM model.
// Expected values are hand-computed constants.
module tb_memctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        iDC_en = 1'b0;
  logic        iDC_ls = 1'b0;
  logic [31:0] iDC_pc = '0;
  logic [31:0] iDC_dt = '0;
  logic [2:0]  iDC_len = '0;
  logic        oDC_done;
  logic [31:0] oDC_dt;
  logic        iIC_en = 1'b0;
  logic [31:0] iIC_pc = '0;
  logic        oIC_done;
  logic [31:0] oIC_dt;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  memctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .iDC_en(iDC_en), .iDC_ls(iDC_ls), .iDC_pc(iDC_pc),
    .iDC_dt(iDC_dt), .iDC_len(iDC_len),
    .oDC_done(oDC_done), .oDC_dt(oDC_dt),
    .iIC_en(iIC_en), .iIC_pc(iIC_pc),
    .oIC_done(oIC_done), .oIC_dt(oIC_dt),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  logic [7:0] ram [0:262143];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
  end

  int wr_n = 0;
  int dc_n = 0;
  int both_n = 0;
  logic [31:0] wa [0:63];
  logic [7:0]  wd [0:63];
  int          wc [0:63];

  always @(negedge clk) begin
    if (mem_wr && wr_n < 64) begin
      wa[wr_n] <= mem_a;
      wd[wr_n] <= mem_dout;
      wc[wr_n] <= cyc;
    end
    if (mem_wr) wr_n <= wr_n + 1;
    if (oDC_done) dc_n <= dc_n + 1;
    if (oDC_done && oIC_done) both_n <= both_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dc_go(input logic ls, input logic [31:0] pc,
                       input logic [31:0] dt, input logic [2:0] len);
    iDC_en  = 1'b1;
    iDC_ls  = ls;
    iDC_pc  = pc;
    iDC_dt  = dt;
    iDC_len = len;
    t0 = cyc;
    tick();
    iDC_en = 1'b0;
  endtask

  task automatic wait_dc(output int lat, output logic [31:0] dt);
    lat = -1;
    dt  = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (oDC_done) begin
        lat = cyc - t0;
        dt  = oDC_dt;
        break;
      end
      tick();
    end
    tick();
  endtask

  int lat, wb, dsnap, dc_at, ic_at;
  logic [31:0] dt, dcv, icv;

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] <= 8'h00;
    ram[32'h100] <= 8'h11;
    ram[32'h101] <= 8'h22;
    ram[32'h102] <= 8'h33;
    ram[32'h103] <= 8'h44;
    ram[32'h000] <= 8'h93;
    ram[32'h001] <= 8'h05;
    ram[32'h002] <= 8'h10;
    ram[32'h003] <= 8'h00;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_dc_done", {31'b0, oDC_done}, 32'h0);
    chk("rst_ic_done", {31'b0, oIC_done}, 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    dc_go(1'b0, 32'h101, 32'h0, 3'd1);
    wait_dc(lat, dt);
    chk("ld1_lat", lat, 32'd3);
    chk("ld1_dt", dt, 32'h00000022);

    dc_go(1'b0, 32'h102, 32'h0, 3'd2);
    wait_dc(lat, dt);
    chk("ld2_lat", lat, 32'd4);
    chk("ld2_dt", dt, 32'h00004433);

    dsnap = dc_n;
    dc_go(1'b0, 32'h100, 32'h0, 3'd4);
    tick();
    tick();
    @(negedge clk);
    chk("mid_addr2", mem_a, 32'h102);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstm_mem_a", mem_a, 32'h0);
    chk("rstm_dc_dt", oDC_dt, 32'h0);
    chk("rstm_done", {30'b0, oDC_done, oIC_done}, 32'h0);
    chk("rstm_wr", {23'b0, mem_wr, mem_dout}, 32'h0);
    repeat (10) tick();
    chk("rstm_no_done", dc_n, dsnap);

    wb = wr_n;
    dc_go(1'b1, 32'h200, 32'hDEADBEEF, 3'd4);
    wait_dc(lat, dt);
    chk("st4_lat", lat, 32'd5);
    chk("st4_dt", dt, 32'h0);
    chk("st4_nwr", wr_n - wb, 32'd4);
    chk("st4_c0", wc[wb] - t0, 32'd1);
    chk("st4_w0", {wa[wb], wd[wb]} & 40'hFFFF_FFFF_FF, {32'h200, 8'hEF});
    chk("st4_w1", {wa[wb+1][23:0], wd[wb+1]}, {24'h201, 8'hBE});
    chk("st4_w2", {wa[wb+2][23:0], wd[wb+2]}, {24'h202, 8'hAD});
    chk("st4_w3", {wa[wb+3][23:0], wd[wb+3]}, {24'h203, 8'hDE});

    dc_go(1'b0, 32'h200, 32'h0, 3'd4);
    wait_dc(lat, dt);
    chk("ld4_lat", lat, 32'd6);
    chk("ld4_dt", dt, 32'hDEADBEEF);

    iIC_en  = 1'b1;
    iIC_pc  = 32'h0;
    iDC_en  = 1'b1;
    iDC_ls  = 1'b0;
    iDC_pc  = 32'h100;
    iDC_len = 3'd4;
    t0 = cyc;
    dc_at = -1;
    ic_at = -1;
    dcv = '0;
    icv = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (oDC_done && dc_at < 0) begin
        dc_at = cyc - t0;
        dcv = oDC_dt;
      end
      if (oIC_done && ic_at < 0) begin
        ic_at = cyc - t0;
        icv = oIC_dt;
      end
      tick();
      iDC_en = 1'b0;
      if (ic_at >= 0) iIC_en = 1'b0;
    end
    iIC_en = 1'b0;
    chk("arb_dc_at", dc_at, 32'd6);
    chk("arb_dc_dt", dcv, 32'h44332211);
    chk("arb_ic_at", ic_at, 32'd12);
    chk("arb_ic_dt", icv, 32'h00100593);
    chk("arb_overlap", both_n, 32'd0);

    wb = wr_n;
    dc_go(1'b1, 32'h30000, 32'h41, 3'd1);
    io_buffer_full = 1'b1;
    tick();
    tick();
    tick();
    io_buffer_full = 1'b0;
    wait_dc(lat, dt);
    chk("io_lat", lat, 32'd5);
    chk("io_nwr", wr_n - wb, 32'd1);
    chk("io_wcyc", wc[wb] - t0, 32'd4);
    chk("io_w0", {wa[wb], 24'h0, wd[wb]}, {32'h30000, 32'h41});

    dc_go(1'b0, 32'h100, 32'h0, 3'd4);
    tick();
    rdy = 1'b0;
    tick();
    tick();
    rdy = 1'b1;
    wait_dc(lat, dt);
    chk("rdy_ld_lat", lat, 32'd8);
    chk("rdy_ld_dt", dt, 32'h44332211);

    wb = wr_n;
    iDC_en  = 1'b1;
    iDC_ls  = 1'b1;
    iDC_pc  = 32'h300;
    iDC_dt  = 32'h0000A5B6;
    iDC_len = 3'd2;
    t0 = cyc;
    tick();
    iDC_en = 1'b0;
    rdy = 1'b0;
    @(negedge clk);
    chk("rdy_st_wr0", {31'b0, mem_wr}, 32'h0);
    tick();
    rdy = 1'b1;
    wait_dc(lat, dt);
    chk("rdy_st_lat", lat, 32'd4);
    chk("rdy_st_nwr", wr_n - wb, 32'd2);
    chk("rdy_st_wcyc", wc[wb] - t0, 32'd2);
    chk("rdy_st_w1", {wa[wb+1][23:0], wd[wb+1]}, {24'h301, 8'hA5});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
